// File: rtl/compare_operand_sequencer.sv
// Operand sequencer for the mini-ALU greater-or-equal comparator: collects A then B,
// holds them on op_a/op_b, samples the comparator after one settle cycle, and hands off the result.
module compare_operand_sequencer #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic             geq_in,
    output logic             res_geq,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] cmp_count
);

    typedef enum logic [1:0] {StA, StB, StCmp, StOut} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       op_a_q, op_a_d;
    logic [W-1:0]       op_b_q, op_b_d;
    logic               res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    assign in_ready  = (state_q == StA) || (state_q == StB);
    assign res_valid = (state_q == StOut);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        if (clr) begin
            // Abort drops any pending operands/result but keeps the completion count.
            state_d = StA;
            op_a_d  = '0;
            op_b_d  = '0;
            res_d   = 1'b0;
        end else begin
            unique case (state_q)
                StA: begin
                    if (accept) begin
                        op_a_d  = in_data;
                        state_d = StB;
                    end
                end
                StB: begin
                    if (accept) begin
                        op_b_d  = in_data;
                        state_d = StCmp;
                    end
                end
                StCmp: begin
                    res_d   = geq_in;
                    state_d = StOut;
                end
                StOut: begin
                    if (res_ready) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StA;
                    end
                end
                default: state_d = StA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StA;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign res_geq   = res_q;
    assign cmp_count = cnt_q;

endmodule
